// File: rtl/regbank_pkg.sv
// regbank_pkg: shared register-bank constants and dump sequencer states
package regbank_pkg;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  typedef enum logic [2:0] {IDLE, FETCH, SEND0, SEND1, SUM} dump_state_e;
endpackage

// File: rtl/regbank_dump.sv
// regbank_dump: streams a register range out of the bank two reads at a time, then an XOR checksum word
module regbank_dump
  import regbank_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  input  logic          abort,
  output logic [AW-1:0] sr1,
  output logic [AW-1:0] sr2,
  input  logic [DW-1:0] rdData1,
  input  logic [DW-1:0] rdData2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  dump_state_e state, state_n;
  logic [AW-1:0] ptr, ptr_n, end_ptr, end_n, addr_n;
  logic [DW-1:0] buf0, buf0_n, buf1, buf1_n, chk, chk_n, data_n;
  logic have1, have1_n, done_n;
  assign sr1 = ptr;
  assign sr2 = ptr + AW'(1);
  // In SEND*/SUM out_valid is high, so out_ready alone marks a handshake
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    end_n = end_ptr;
    buf0_n = buf0;
    buf1_n = buf1;
    chk_n = chk;
    have1_n = have1;
    done_n = 1'b0;
    if (abort && state != IDLE) state_n = IDLE;
    else case (state)
      IDLE: if (start) begin
        if (first <= last) begin
          state_n = FETCH;
          ptr_n = first;
          end_n = last;
          chk_n = '0;
        end else done_n = 1'b1;
      end
      FETCH: begin
        buf0_n = rdData1;
        buf1_n = rdData2;
        have1_n = ptr != end_ptr;
        state_n = SEND0;
      end
      SEND0: if (out_ready) begin
        chk_n = chk ^ buf0;
        state_n = have1 ? SEND1 : SUM;
      end
      SEND1: if (out_ready) begin
        chk_n = chk ^ buf1;
        if (ptr + AW'(1) == end_ptr) state_n = SUM;
        else begin
          ptr_n = ptr + AW'(2);
          state_n = FETCH;
        end
      end
      default: if (out_ready) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    endcase
    data_n = state_n == SEND0 ? buf0_n : state_n == SEND1 ? buf1_n : state_n == SUM ? chk_n : '0;
    addr_n = state_n == SEND0 ? ptr_n : state_n == SEND1 ? ptr_n + AW'(1) : state_n == SUM ? end_n : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      end_ptr <= '0;
      buf0 <= '0;
      buf1 <= '0;
      chk <= '0;
      have1 <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      end_ptr <= end_n;
      buf0 <= buf0_n;
      buf1 <= buf1_n;
      chk <= chk_n;
      have1 <= have1_n;
      out_valid <= state_n inside {SEND0, SEND1, SUM};
      out_last <= state_n == SUM;
      out_data <= data_n;
      out_addr <= addr_n;
      busy <= state_n != IDLE;
      done <= done_n;
    end
  end
endmodule

// File: doc/regbank_dump.md
Name: regbank_dump

Overview:
- Read-side sequencer for the 32 x 32 register bank: drives the bank's two read-address ports and consumes the combinational read data.
- Streams a contiguous register range [first..last] out over a valid/ready interface, one word per handshake.
- Ends each dump with an XOR checksum word.
- Used for debug register dumps and scan-out. It never writes the bank.

Parameters:
- NREGS, 32, number of registers in the bank.
- AW, 5, register address width (log2 NREGS).
- DW, 32, data width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state.
- start  in  1  begin dump; sampled only in IDLE.
- first  in  AW  first register index, sampled with start.
- last  in  AW  last register index, sampled with start.
- abort  in  1  cancel an active dump.
- sr1  out  AW  read address 1 to bank; equals ptr.
- sr2  out  AW  read address 2 to bank; equals ptr+1 modulo NREGS.
- rdData1  in  DW  bank read data for sr1 (combinational from bank).
- rdData2  in  DW  bank read data for sr2.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer accepts word.
- out_data  out  DW  register value, or checksum when out_last=1.
- out_addr  out  AW  register index of out_data (checksum word: equals last).
- out_last  out  1  marks the checksum word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on dump completion.

Behaviour:
- Reset values: state=IDLE, ptr=0 (so sr1=0, sr2=1), out_valid=0, out_last=0, out_data=0, out_addr=0, busy=0, done=0, checksum=0, buffers=0.
- Reset takes priority over everything. Reset mid-dump returns to IDLE at that edge; no done pulse, no further words.
- States: IDLE, FETCH, SEND0, SEND1, SUM.
- IDLE, start=1, first<=last: latch ptr=first, end=last, checksum=0; go to FETCH.
- IDLE, start=1, first>last: stay IDLE; done pulses the next cycle; no words emitted.
- start is ignored while busy.
- FETCH (1 cycle): capture buf0=rdData1 and buf1=rdData2; set have1=(ptr!=end); go to SEND0. This is a snapshot: bank writes after the FETCH edge are not reflected in buffered words.
- SEND0: out_valid=1, out_data=buf0, out_addr=ptr.
  - On handshake: checksum^=buf0.
  - have1 -> SEND1, else -> SUM.
- SEND1: out_valid=1, out_data=buf1, out_addr=ptr+1.
  - On handshake: checksum^=buf1.
  - ptr+1==end -> SUM, else ptr+=2 and -> FETCH.
- SUM: out_valid=1, out_last=1, out_data=checksum, out_addr=end. On handshake: -> IDLE, done=1 for one cycle.
- Handshake = out_valid & out_ready at a rising edge. While out_valid=1 and out_ready=0, out_data, out_addr and out_last hold stable.
- abort=1 in any busy state: -> IDLE next edge; out_valid drops; no checksum word; no done. abort has lower priority than reset and higher priority than a handshake in the same cycle (that word counts as not transferred).
- Wrap: ptr=31 gives sr2=0. The sr2 read data is unused because end<=31 forces have1=0.
- Latency: start at edge N -> FETCH in cycle N+1 -> first out_valid in cycle N+2.
- Throughput with out_ready held high: 2 words per 3 cycles.
- Word count per dump = last-first+1 data words, plus 1 checksum word.
- All outputs are registered except sr1/sr2, which are decoded from the ptr register.

Decomposition:
- Shared package regbank_pkg holds NREGS, AW, DW constants and the dump state enumeration (IDLE, FETCH, SEND0, SEND1, SUM). The bank and this block both import it.
- Single module; no sub-module needed (checksum and buffer are a few registers).

Test Plan:
- Reset: bank preloaded r[k]=0x100+k; hold reset=0 for 2 cycles -> all outputs 0, sr1=0, sr2=1, busy=0.
- Basic dump: start, first=4, last=7, out_ready=1 -> first valid 2 cycles after start. Words 0x104,0x105,0x106,0x107 at addr 4..7, then out_last=1 with data 0x00000000. done pulses one cycle after the final handshake.
- Single/odd range: first=last=31 -> one word 0x11F at addr 31, sr2=0 during FETCH, then checksum 0x0000011F, done.
- Backpressure: first=0, last=5 with out_ready randomly toggled -> identical sequence 0x100..0x105 plus checksum 0x00000001. Data and addr stable during every stall.
- Empty/ignored: start with first=8, last=3 -> no out_valid, done pulse next cycle. start while busy -> no effect on the current dump.
- Mid-operation cancel: reset=0 during SEND1 of a 0..9 dump -> next cycle out_valid=0, busy=0, no done. Same for abort=1. A following start with first=2, last=3 produces 0x102, 0x103, checksum 0x00000001.
